fetch_ifid: RTL

FETCH_IFID -- requirements
Module: fetch_ifid

---
 rtl/fetch_ifid_pkg.sv | 12 +
 rtl/cla_16b.sv | 56 +++++
 rtl/fetch_ifid.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_ifid_pkg.sv
// Shared pipeline definitions: fetch state encodings and the decode bubble word.
package fetch_ifid_pkg;

    localparam int unsigned FETCH_ST_W = 2;

    localparam logic [FETCH_ST_W-1:0] ST_REQ  = 2'd0;
    localparam logic [FETCH_ST_W-1:0] ST_BUF  = 2'd1;
    localparam logic [FETCH_ST_W-1:0] ST_HALT = 2'd2;

    localparam logic [15:0] IFID_NOP_INSTR = 16'h0800;

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder: four 4-bit groups joined by a second lookahead level.
module cla_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  bg;
    logic [3:0]  bp;
    logic [4:0]  bc;
    logic        carry;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        bg = '0;
        bp = '0;
        for (int k = 0; k < 4; k++) begin
            bp[k] = &p[4*k +: 4];
            bg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Group carries resolved in parallel from group generate/propagate.
    assign bc[0] = c_in;
    assign bc[1] = bg[0] | (bp[0] & c_in);
    assign bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & c_in);
    assign bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                 | (bp[2] & bp[1] & bp[0] & c_in);
    assign bc[4] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                 | (bp[3] & bp[2] & bp[1] & bg[0])
                 | (bp[3] & bp[2] & bp[1] & bp[0] & c_in);

    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int k = 0; k < 4; k++) begin
            carry = bc[k];
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ carry;
                carry      = g[4*k+j] | (p[4*k+j] & carry);
            end
        end
    end

    assign c_out = bc[4];

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage with IF/ID pipeline register and a one-entry skid buffer that
// catches a word returned while decode is stalled.
module fetch_ifid
    import fetch_ifid_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = IFID_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] instruction,
    output logic [15:0] PC_2,
    output logic        ifid_valid,
    output logic        err
);

    logic [FETCH_ST_W-1:0] state;
    logic [15:0]           pc;
    logic [15:0]           pc_plus2;
    logic                  pc_carry_unused;
    logic [15:0]           ifid_instr;
    logic [15:0]           ifid_pc2;
    logic [15:0]           skid_instr;
    logic [15:0]           skid_pc2;

    cla_16b u_pc_add (
        .a     (pc),
        .b     (16'h0002),
        .c_in  (1'b0),
        .sum   (pc_plus2),
        .c_out (pc_carry_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_REQ;
            pc         <= RESET_PC;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc2   <= 16'h0000;
            skid_instr <= 16'h0000;
            skid_pc2   <= 16'h0000;
            err        <= 1'b0;
        end else if (state != ST_HALT) begin
            if (flush) begin
                // A misaligned target is fatal: freeze PC and stop fetching.
                ifid_valid <= 1'b0;
                if (redirect_pc[0]) begin
                    err   <= 1'b1;
                    state <= ST_HALT;
                end else begin
                    pc    <= redirect_pc;
                    state <= ST_REQ;
                end
            end else if (halt && !stall) begin
                ifid_valid <= 1'b0;
                state      <= ST_HALT;
            end else if (state == ST_REQ) begin
                if (imem_ready) begin
                    pc <= pc_plus2;
                    if (stall) begin
                        skid_instr <= imem_data;
                        skid_pc2   <= pc_plus2;
                        state      <= ST_BUF;
                    end else begin
                        ifid_instr <= imem_data;
                        ifid_pc2   <= pc_plus2;
                        ifid_valid <= 1'b1;
                    end
                end else if (!stall) begin
                    ifid_valid <= 1'b0;
                end
            end else if (!stall) begin
                ifid_instr <= skid_instr;
                ifid_pc2   <= skid_pc2;
                ifid_valid <= 1'b1;
                state      <= ST_REQ;
            end
        end
    end

    assign imem_rd     = (state == ST_REQ);
    assign imem_addr   = pc;
    assign instruction = ifid_valid ? ifid_instr : NOP_INSTR;
    assign PC_2        = ifid_pc2;

endmodule
